// File: rtl/load_data_extender.sv
// load_data_extender: picks a byte/half/word/dword lane from an aligned load word, extends it and sends it downstream through a 2-entry skid buffer.
module load_data_extender #(
  parameter int DATA_W = 32,
  parameter int TAG_W = 5,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [15:0]       err_count
);
  logic [6:0] w;
  logic [DATA_W-1:0] sh, mask, ext;
  logic msb, err, accept;
  logic [DATA_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic skid_err;
  // mask covers the field; a field as wide as the datapath shifts the ones out, so nothing is extended
  always_comb begin
    w = 7'd8 << in_size;
    sh = in_data >> {in_offset, 3'b000};
    mask = ~({DATA_W{1'b1}} << w);
    msb = |(sh & mask & ~(mask >> 1));
    err = (w > 7'(DATA_W)) || |(in_offset & OFF_W'((w >> 3) - 7'd1));
    ext = err ? '0 : (sh & mask) | ((in_signed && msb) ? ~mask : '0);
    accept = in_valid && in_ready;
  end
  // the skid entry is full exactly when in_ready is low
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_tag <= '0;
      out_err <= 1'b0;
      skid_data <= '0;
      skid_tag <= '0;
      skid_err <= 1'b0;
      err_count <= '0;
    end else begin
      if (!out_valid || out_ready) begin
        out_valid <= !in_ready || accept;
        out_data <= !in_ready ? skid_data : ext;
        out_tag <= !in_ready ? skid_tag : in_tag;
        out_err <= !in_ready ? skid_err : err;
        in_ready <= 1'b1;
      end else if (accept) begin
        skid_data <= ext;
        skid_tag <= in_tag;
        skid_err <= err;
        in_ready <= 1'b0;
      end
      if (accept && err && !(&err_count)) err_count <= err_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_load_data_extender.sv
// tb_load_data_extender: drives a 32-bit and a 64-bit instance with the same beats and scoreboards both against a lane/extension reference model.
module tb_load_data_extender;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  logic in_valid = 1'b0, sgn = 1'b0;
  logic [63:0] d = '0;
  logic [1:0] sz = '0;
  logic [2:0] off = '0;
  logic [4:0] tag = '0;
  logic rand_mode = 1'b0, fixed_rdy = 1'b1, rr = 1'b1, out_ready;
  assign out_ready = rand_mode ? rr : fixed_rdy;

  logic r32, v32, e32, r64, v64, e64;
  logic [31:0] d32;
  logic [63:0] d64;
  logic [4:0] t32, t64;
  logic [15:0] c32, c64;

  load_data_extender #(.DATA_W(32), .TAG_W(5)) u32 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(r32),
    .in_data(d[31:0]), .in_size(sz), .in_signed(sgn), .in_offset(off[1:0]), .in_tag(tag),
    .out_valid(v32), .out_ready(out_ready), .out_data(d32), .out_tag(t32),
    .out_err(e32), .err_count(c32));
  load_data_extender #(.DATA_W(64), .TAG_W(5)) u64 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(r64),
    .in_data(d), .in_size(sz), .in_signed(sgn), .in_offset(off), .in_tag(tag),
    .out_valid(v64), .out_ready(out_ready), .out_data(d64), .out_tag(t64),
    .out_err(e64), .err_count(c64));

  always begin
    @(posedge clock);
    #1 rr = 1'($urandom_range(0, 1));
  end

  typedef struct packed {logic [63:0] data; logic [4:0] tag; logic err;} exp_t;
  exp_t q32[$], q64[$];
  int cnt32 = 0, cnt64 = 0, passed = 0, total = 0;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", n, got, exp);
  endtask

  // reference: take nbytes starting at byte off bit by bit, then fill upward with the sign bit
  function automatic logic [64:0] model(input logic [63:0] dd, input logic [1:0] s,
                                        input logic sg, input int o, input int dw);
    int nb = 1 << s;
    int bits = 8 * nb;
    logic [63:0] v = '0;
    if (bits > dw || (o % nb) != 0) return {1'b1, 64'd0};
    for (int b = 0; b < bits; b++) v[b] = dd[8 * o + b];
    if (sg && bits < dw && v[bits - 1])
      for (int b = bits; b < dw; b++) v[b] = 1'b1;
    return {1'b0, v};
  endfunction

  logic stall32 = 1'b0, stall64 = 1'b0;
  logic [37:0] hold32;
  logic [69:0] hold64;
  exp_t e;
  always @(negedge clock) begin
    if (reset) begin
      stall32 = 1'b0;
      stall64 = 1'b0;
    end else begin
      chk("err_count32", 64'(c32), 64'(cnt32));
      chk("err_count64", 64'(c64), 64'(cnt64));
      if (stall32) chk("hold32", {v32, d32, t32, e32}, {1'b1, hold32});
      if (stall64) chk("hold64", {v64, d64[62:0], t64, e64}, {1'b1, hold64[68:0]});
      if (v32 && out_ready) begin
        if (q32.size() == 0) chk("extra_beat32", 64'(q32.size()), 64'd1);
        else begin
          e = q32.pop_front();
          chk("data32", 64'(d32), e.data);
          chk("tag32", 64'(t32), 64'(e.tag));
          chk("err32", 64'(e32), 64'(e.err));
        end
      end
      if (v64 && out_ready) begin
        if (q64.size() == 0) chk("extra_beat64", 64'(q64.size()), 64'd1);
        else begin
          e = q64.pop_front();
          chk("data64", d64, e.data);
          chk("tag64", 64'(t64), 64'(e.tag));
          chk("err64", 64'(e64), 64'(e.err));
        end
      end
      stall32 = v32 && !out_ready;
      stall64 = v64 && !out_ready;
      hold32 = {d32, t32, e32};
      hold64 = {d64, t64, e64};
    end
  end

  task automatic send(input logic [63:0] dd, input logic [1:0] s, input logic sg,
                      input logic [2:0] o, input logic [4:0] t);
    logic [64:0] m32, m64;
    bit ok = 0;
    d = dd; sz = s; sgn = sg; off = o; tag = t; in_valid = 1'b1;
    m32 = model(dd & 64'hFFFF_FFFF, s, sg, int'(o[1:0]), 32);
    m64 = model(dd, s, sg, int'(o), 64);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      ok = r32;
    end
    if (!ok) chk("accept_timeout", 64'(r32), 64'd1);
    else begin
      chk("ready_match", 64'(r64), 64'(r32));
      q32.push_back('{data: m32[63:0], tag: t, err: m32[64]});
      q64.push_back('{data: m64[63:0], tag: t, err: m64[64]});
    end
    @(posedge clock);
    if (ok && m32[64] && cnt32 != 65535) cnt32++;
    if (ok && m64[64] && cnt64 != 65535) cnt64++;
    #1 in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    cnt32 = 0;
    cnt64 = 0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", 64'({v32, v64}), 64'd0);
    chk("rst_ready", 64'({r32, r64}), 64'd3);
    chk("rst_data", d64 | 64'(d32), 64'd0);
    chk("rst_tag_err", 64'({t32, t64, e32, e64}), 64'd0);
    chk("rst_count", 64'({c32, c64}), 64'd0);
    @(posedge clock);
    #1;
    send(64'h80FF7F01, 2'b00, 1, 3'd3, 5'd1);
    send(64'h80FF7F01, 2'b00, 0, 3'd3, 5'd2);
    send(64'h80FF7F01, 2'b00, 1, 3'd1, 5'd3);
    send(64'h80011234, 2'b01, 1, 3'd2, 5'd4);
    send(64'h80011234, 2'b01, 1, 3'd1, 5'd5);
    send(64'h80000000_12345678, 2'b11, 0, 3'd0, 5'd6);
    send(64'h80000000_12345678, 2'b10, 1, 3'd4, 5'd7);
    send(64'h80000000_12345678, 2'b10, 1, 3'd2, 5'd8);
    for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 2'($urandom_range(0, 2)), 1'($urandom), 3'd0, 5'(i));
    repeat (3) @(posedge clock);
    #1 fixed_rdy = 1'b0;
    send(64'hA5A5_5A5A_F00D_BEEF, 2'b00, 1, 3'd0, 5'd10);
    send(64'hA5A5_5A5A_F00D_BEEF, 2'b01, 1, 3'd2, 5'd11);
    in_valid = 1'b1;
    @(negedge clock);
    chk("skid_full_ready32", 64'(r32), 64'd0);
    chk("skid_full_ready64", 64'(r64), 64'd0);
    in_valid = 1'b0;
    fixed_rdy = 1'b1;
    @(posedge clock);
    #1;
    send(64'h0123_4567_89AB_CDEF, 2'b00, 0, 3'd5, 5'd12);
    repeat (4) @(posedge clock);
    #1 fixed_rdy = 1'b0;
    send(64'h1234, 2'b01, 1, 3'd1, 5'd13);
    send(64'hFFFF_FFFF, 2'b00, 1, 3'd0, 5'd14);
    do_reset();
    @(negedge clock);
    chk("midrst_valid", 64'({v32, v64}), 64'd0);
    chk("midrst_ready", 64'({r32, r64}), 64'd3);
    chk("midrst_count", 64'({c32, c64}), 64'd0);
    fixed_rdy = 1'b1;
    @(posedge clock);
    #1 rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      send({$urandom, $urandom}, 2'($urandom), 1'($urandom), 3'($urandom), 5'($urandom));
    end
    rand_mode = 1'b0;
    for (int i = 0; i < 20 && (q32.size() + q64.size()) != 0; i++) @(posedge clock);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain64", 64'(q64.size()), 64'd0);
    #1;
    for (int i = 0; i < 65540; i++) send({$urandom, $urandom}, 2'b01, 1'($urandom), 3'd1, 5'(i));
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("sat32", 64'(c32), 64'hFFFF);
    chk("sat64", 64'(c64), 64'hFFFF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
